// File: rtl/pca_seq_ctrl_if.sv
// Request/result bundle for the nibble-serial parity-checked adder controller.
// The master side drives the operation request, the slave side returns status and result.
interface pca_seq_ctrl_if #(
    parameter int NIB = 4
);
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    logic              start;
    logic [4*NIB-1:0]  x;
    logic [4*NIB-1:0]  y;
    logic              ci;
    logic              flt_en;
    logic [IW-1:0]     flt_nib;
    logic [3:0]        flt_mask;
    logic [1:0]        flt_hits;
    logic              busy;
    logic              done;
    logic [4*NIB-1:0]  z;
    logic              co;
    logic              err;
    logic [7:0]        retries;

    modport master (
        output start, x, y, ci, flt_en, flt_nib, flt_mask, flt_hits,
        input  busy, done, z, co, err, retries
    );

    modport slave (
        input  start, x, y, ci, flt_en, flt_nib, flt_mask, flt_hits,
        output busy, done, z, co, err, retries
    );
endinterface

// File: rtl/pca_seq_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice with carry-parity checking is stepped
// LSB-first across the operands, retrying a nibble on parity error and aborting when out of retries.
module pca_seq_ctrl #(
    parameter int NIB       = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic          clk,
    input  logic          rst,
    pca_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic            r_fltEn;
    logic [IW-1:0]   r_fltNib;
    logic [3:0]      r_fltMask;
    logic [1:0]      r_hitsLeft;
    logic            r_cin;
    logic [IW-1:0]   r_idx;
    logic [RW-1:0]   r_rc;
    logic [W-1:0]    r_z;
    logic            r_co;
    logic            r_err;
    logic [7:0]      r_retries;

    logic [3:0]      w_xn;
    logic [3:0]      w_yn;
    logic [3:0]      w_zn;
    logic [4:0]      w_carry;
    logic            w_cp;
    logic            w_zp;
    logic            w_zpe;
    logic            w_parOk;
    logic            w_fltActive;
    logic [3:0]      w_f;
    logic            w_isLast;
    logic            w_sliceCo;

    logic            w_busy;
    logic            w_done;
    logic            w_accept;
    logic            w_commit;
    logic            w_retry;
    logic            w_abort;

    // Operand nibble select and the ripple slice; carries into each bit feed the parity predictor.
    always_comb begin
        w_xn    = '0;
        w_yn    = '0;
        w_zn    = '0;
        w_carry = '0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IW'(n)) begin
                w_xn = r_x[4*n +: 4];
                w_yn = r_y[4*n +: 4];
            end
        end
        w_carry[0] = r_cin;
        for (int b = 0; b < 4; b++) begin
            w_zn[b]        = w_xn[b] ^ w_yn[b] ^ w_carry[b];
            w_carry[b + 1] = (w_xn[b] & w_yn[b]) | (w_xn[b] & w_carry[b]) | (w_yn[b] & w_carry[b]);
        end
    end

    assign w_sliceCo   = w_carry[4];
    assign w_cp        = ^w_carry[3:0];
    assign w_fltActive = (r_state == S_RUN) && r_fltEn && (r_idx == r_fltNib) && (r_hitsLeft != 2'd0);
    assign w_f         = w_fltActive ? r_fltMask : 4'd0;
    assign w_zp        = w_cp ^ (^w_xn) ^ (^w_yn);
    assign w_zpe       = ^(w_zn ^ w_f);
    assign w_parOk     = (w_zp == w_zpe);
    assign w_isLast    = (r_idx == IW'(NIB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_retry     = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_parOk) begin
                    w_commit = 1'b1;
                    if (w_isLast) begin
                        w_nextState = S_DONE;
                    end
                end else if (r_rc < RW'(MAX_RETRY)) begin
                    w_retry = 1'b1;
                end else begin
                    w_abort     = 1'b1;
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Result registers hold after completion until the next accepted request clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_fltEn    <= 1'b0;
            r_fltNib   <= '0;
            r_fltMask  <= '0;
            r_hitsLeft <= '0;
            r_cin      <= 1'b0;
            r_idx      <= '0;
            r_rc       <= '0;
            r_z        <= '0;
            r_co       <= 1'b0;
            r_err      <= 1'b0;
            r_retries  <= '0;
        end else begin
            if (w_accept) begin
                r_x        <= bus.x;
                r_y        <= bus.y;
                r_fltEn    <= bus.flt_en;
                r_fltNib   <= bus.flt_nib;
                r_fltMask  <= bus.flt_mask;
                r_hitsLeft <= bus.flt_hits;
                r_cin      <= bus.ci;
                r_idx      <= '0;
                r_rc       <= '0;
                r_z        <= '0;
                r_co       <= 1'b0;
                r_err      <= 1'b0;
                r_retries  <= '0;
            end
            if (w_fltActive) begin
                r_hitsLeft <= r_hitsLeft - 2'd1;
            end
            if (w_commit) begin
                for (int n = 0; n < NIB; n++) begin
                    if (r_idx == IW'(n)) begin
                        r_z[4*n +: 4] <= w_zn ^ w_f;
                    end
                end
                r_cin <= w_sliceCo;
                r_rc  <= '0;
                if (w_isLast) begin
                    r_co <= w_sliceCo;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
            if (w_retry) begin
                r_rc <= r_rc + RW'(1);
                if (r_retries != 8'hFF) begin
                    r_retries <= r_retries + 8'd1;
                end
            end
            if (w_abort) begin
                r_err <= 1'b1;
                r_co  <= 1'b0;
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.z       = r_z;
    assign bus.co      = r_co;
    assign bus.err     = r_err;
    assign bus.retries = r_retries;
endmodule

// File: tb/tb_pca_seq_ctrl.sv
// Self-checking bench for pca_seq_ctrl: directed cases with literal results plus randomized
// operations compared every cycle against an arithmetic reference model.
module tb_pca_seq_ctrl;
    localparam int NIB       = 4;
    localparam int MAX_RETRY = 2;
    localparam int W         = 4 * NIB;
    localparam int PH_IDLE   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_DONE   = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chkEn;

    int          mPhase;
    int          mLeft;
    logic [W-1:0] mZ, pZ;
    logic        mCo, mErr, pCo, pErr;
    logic [7:0]  mRet, pRet;
    int          pAtt;

    pca_seq_ctrl_if #(.NIB(NIB)) bus ();

    pca_seq_ctrl #(.NIB(NIB), .MAX_RETRY(MAX_RETRY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation arithmetic model: nibble sums, fault XOR, and the retry budget per nibble.
    function automatic void modelOp(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                    input logic fen, input logic [1:0] fnib, input logic [3:0] fmask,
                                    input logic [1:0] fhits, output logic [W-1:0] ez, output logic eco,
                                    output logic eerr, output logic [7:0] eret, output int eatt);
        int hits;
        int cin;
        int rc;
        int s;
        int f;
        bit app;
        bit stop;
        hits = int'(fhits);
        cin  = int'(ci);
        stop = 1'b0;
        ez   = '0;
        eco  = 1'b0;
        eerr = 1'b0;
        eret = '0;
        eatt = 0;
        for (int n = 0; n < NIB && !stop; n++) begin
            rc = 0;
            for (int a = 0; a <= MAX_RETRY; a++) begin
                eatt++;
                s   = int'((x >> (4*n)) & 16'hF) + int'((y >> (4*n)) & 16'hF) + cin;
                app = fen && (n == int'(fnib)) && (hits > 0);
                f   = app ? int'(fmask) : 0;
                if (app) hits--;
                if (($countones(f) % 2) == 0) begin
                    ez  = ez | (16'((s % 16) ^ f) << (4*n));
                    cin = s / 16;
                    break;
                end else if (rc < MAX_RETRY) begin
                    rc++;
                    if (eret != 8'hFF) eret = eret + 8'd1;
                end else begin
                    eerr = 1'b1;
                    stop = 1'b1;
                    break;
                end
            end
        end
        eco = eerr ? 1'b0 : (cin != 0);
    endfunction

    // Cycle-level tracker of the model: idle, running for the predicted number of attempts, done.
    always @(posedge clk) begin
        if (rst) begin
            mPhase = PH_IDLE;
            mLeft  = 0;
            mZ     = '0;
            mCo    = 1'b0;
            mErr   = 1'b0;
            mRet   = '0;
        end else begin
            case (mPhase)
                PH_IDLE: begin
                    if (bus.start) begin
                        modelOp(bus.x, bus.y, bus.ci, bus.flt_en, bus.flt_nib, bus.flt_mask,
                                bus.flt_hits, pZ, pCo, pErr, pRet, pAtt);
                        mZ     = '0;
                        mCo    = 1'b0;
                        mErr   = 1'b0;
                        mRet   = '0;
                        mLeft  = pAtt;
                        mPhase = PH_RUN;
                    end
                end
                PH_RUN: begin
                    mLeft--;
                    if (mLeft == 0) begin
                        mZ     = pZ;
                        mCo    = pCo;
                        mErr   = pErr;
                        mRet   = pRet;
                        mPhase = PH_DONE;
                    end
                end
                default: mPhase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("cyc_busy", 32'(bus.busy), 32'(mPhase != PH_IDLE));
            checkOutput("cyc_done", 32'(bus.done), 32'(mPhase == PH_DONE));
            if (mPhase != PH_RUN) begin
                checkOutput("cyc_z", 32'(bus.z), 32'(mZ));
                checkOutput("cyc_co", 32'(bus.co), 32'(mCo));
                checkOutput("cyc_err", 32'(bus.err), 32'(mErr));
                checkOutput("cyc_retries", 32'(bus.retries), 32'(mRet));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                 input logic fen, input logic [1:0] fnib, input logic [3:0] fmask,
                                 input logic [1:0] fhits);
        @(negedge clk);
        bus.x        = x;
        bus.y        = y;
        bus.ci       = ci;
        bus.flt_en   = fen;
        bus.flt_nib  = fnib;
        bus.flt_mask = fmask;
        bus.flt_hits = fhits;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        if (bus.done !== 1'b1) begin
            checkOutput("done_timeout", 32'(bus.done), 32'd1);
        end
    endtask

    task automatic checkResult(input string name, input logic [W-1:0] ez, input logic eco,
                               input logic eerr, input logic [7:0] eret);
        checkOutput({name, "_z"}, 32'(bus.z), 32'(ez));
        checkOutput({name, "_co"}, 32'(bus.co), 32'(eco));
        checkOutput({name, "_err"}, 32'(bus.err), 32'(eerr));
        checkOutput({name, "_retries"}, 32'(bus.retries), 32'(eret));
    endtask

    initial begin
        int lat;
        logic [W-1:0] tz;
        logic tco, terr;
        logic [7:0] tret;
        int tatt;

        total = 0;
        bad   = 0;
        chkEn = 1'b0;
        rst   = 1'b1;
        bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.ci = 1'b0;
        bus.flt_en = 1'b0; bus.flt_nib = '0; bus.flt_mask = '0; bus.flt_hits = '0;
        repeat (3) @(negedge clk);
        chkEn = 1'b1;
        rst   = 1'b0;

        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_z", 32'(bus.z), 32'd0);
        checkOutput("rst_co", 32'(bus.co), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_retries", 32'(bus.retries), 32'd0);

        modelOp(16'h1234, 16'h1111, 1'b0, 1'b1, 2'd1, 4'h1, 2'd1, tz, tco, terr, tret, tatt);
        checkOutput("model_retry_z", 32'(tz), 32'h2345);
        checkOutput("model_retry_att", 32'(tatt), 32'd5);
        modelOp(16'h1234, 16'h1111, 1'b0, 1'b1, 2'd1, 4'h1, 2'd3, tz, tco, terr, tret, tatt);
        checkOutput("model_abort_z", 32'(tz), 32'h0005);
        checkOutput("model_abort_ret", 32'(tret), 32'd2);

        applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0);
        waitDone(lat);
        checkOutput("small_latency", 32'(lat), 32'd4);
        checkResult("small", 16'h0006, 1'b0, 1'b0, 8'd0);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0);
        waitDone(lat);
        checkResult("ripple", 16'h0000, 1'b1, 1'b0, 8'd0);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2'd0, 4'h0, 2'd0);
        waitDone(lat);
        checkResult("allones", 16'hFFFF, 1'b1, 1'b0, 8'd0);

        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1, 2'd1, 4'h1, 2'd1);
        waitDone(lat);
        checkOutput("retry_latency", 32'(lat), 32'd5);
        checkResult("retry", 16'h2345, 1'b0, 1'b0, 8'd1);

        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1, 2'd1, 4'h1, 2'd3);
        waitDone(lat);
        checkResult("abort", 16'h0005, 1'b0, 1'b1, 8'd2);

        // A second request arriving mid-operation must not disturb the first.
        applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0);
        bus.x = 16'hAAAA; bus.y = 16'h5555; bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(lat);
        checkResult("ignored_start", 16'h0006, 1'b0, 1'b0, 8'd0);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkResult("midrst", 16'h0000, 1'b0, 1'b0, 8'd0);
        applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0);
        waitDone(lat);
        checkResult("after_rst", 16'h0006, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          2'($urandom), 4'($urandom), 2'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.x = 16'($urandom); bus.y = 16'($urandom); bus.start = 1'b1;
                    @(negedge clk);
                    bus.start = 1'b0;
                end
                waitDone(lat);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
